// File: rtl/apb_arbiter_2m_pkg.sv
// Shared types for the two-master APB arbiter.
// Holds the FSM state encoding and the timeout-counter width helper.
package apb_arbiter_2m_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2
    } apb_arb_state_e;

    // Width of the ACCESS-phase counter; never below one bit.
    function automatic int tmo_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_arbiter_2m.sv
// Two-master APB arbiter: round-robin grant held for the whole transfer,
// back-to-back hand-off, and an optional ACCESS-phase timeout.
// Ports: clk, rst_n; m0_*/m1_* requester APB ports (psel, penable, paddr,
//   pwrite, pwdata, pwstrb in; pready, prdata, pslverr out);
//   psel..pwstrb out / pready, prdata, pslverr in towards the slave.
module apb_arbiter_2m #(
    parameter int ADDR_W         = 34,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                m0_psel,
    input  logic                m0_penable,
    input  logic [ADDR_W-1:0]   m0_paddr,
    input  logic                m0_pwrite,
    input  logic [DATA_W-1:0]   m0_pwdata,
    input  logic [DATA_W/8-1:0] m0_pwstrb,
    output logic                m0_pready,
    output logic [DATA_W-1:0]   m0_prdata,
    output logic                m0_pslverr,

    input  logic                m1_psel,
    input  logic                m1_penable,
    input  logic [ADDR_W-1:0]   m1_paddr,
    input  logic                m1_pwrite,
    input  logic [DATA_W-1:0]   m1_pwdata,
    input  logic [DATA_W/8-1:0] m1_pwstrb,
    output logic                m1_pready,
    output logic [DATA_W-1:0]   m1_prdata,
    output logic                m1_pslverr,

    output logic                psel,
    output logic                penable,
    output logic [ADDR_W-1:0]   paddr,
    output logic                pwrite,
    output logic [DATA_W-1:0]   pwdata,
    output logic [DATA_W/8-1:0] pwstrb,
    input  logic                pready,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pslverr
);

    import apb_arbiter_2m_pkg::*;

    localparam int CNT_W  = tmo_width(TIMEOUT_CYCLES);
    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    apb_arb_state_e   state_q, state_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] tmo_cnt_q;

    logic             tmo_hit;
    logic             done;
    logic             other_psel;
    logic [DATA_W-1:0] rsp_data;
    logic             rsp_err;

    // Master-side penable carries no information the arbiter needs.
    logic unused_penable;
    assign unused_penable = m0_penable ^ m1_penable;

    // Timeout fires on the last allowed wait cycle; a real pready wins.
    assign tmo_hit = TMO_EN && (state_q == ARB_ACCESS) && !pready
                     && (tmo_cnt_q == TMO_LAST);

    assign done = (state_q == ARB_ACCESS) && (pready || tmo_hit);

    assign other_psel = grant_q ? m0_psel : m1_psel;

    // State register and the saturating ACCESS-phase counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            tmo_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            if (state_q == ARB_SETUP) begin
                tmo_cnt_q <= '0;
            end else if (state_q == ARB_ACCESS && !pready
                         && tmo_cnt_q != CNT_MAX) begin
                tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            ARB_IDLE: begin
                unique case (1'b1)
                    (m0_psel && m1_psel): begin
                        grant_d = ~last_q;
                        state_d = ARB_SETUP;
                    end
                    (m0_psel && !m1_psel): begin
                        grant_d = 1'b0;
                        state_d = ARB_SETUP;
                    end
                    (!m0_psel && m1_psel): begin
                        grant_d = 1'b1;
                        state_d = ARB_SETUP;
                    end
                    default: state_d = ARB_IDLE;
                endcase
            end
            ARB_SETUP: begin
                state_d = ARB_ACCESS;
            end
            ARB_ACCESS: begin
                if (done) begin
                    last_d = grant_q;
                    // Only a real completion hands off; a timeout
                    // abandons the slave and returns to IDLE.
                    if (pready && other_psel) begin
                        grant_d = ~grant_q;
                        state_d = ARB_SETUP;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Outputs: downstream mux and per-master response steering.
    always_comb begin
        psel    = (state_q != ARB_IDLE);
        penable = (state_q == ARB_ACCESS);
        paddr   = '0;
        pwrite  = 1'b0;
        pwdata  = '0;
        pwstrb  = '0;
        if (state_q != ARB_IDLE) begin
            if (grant_q) begin
                paddr  = m1_paddr;
                pwrite = m1_pwrite;
                pwdata = m1_pwdata;
                pwstrb = m1_pwstrb;
            end else begin
                paddr  = m0_paddr;
                pwrite = m0_pwrite;
                pwdata = m0_pwdata;
                pwstrb = m0_pwstrb;
            end
        end

        rsp_data = tmo_hit ? '0 : prdata;
        rsp_err  = tmo_hit ? 1'b1 : pslverr;

        m0_pready  = done && !grant_q;
        m0_prdata  = (done && !grant_q) ? rsp_data : '0;
        m0_pslverr = done && !grant_q && rsp_err;
        m1_pready  = done && grant_q;
        m1_prdata  = (done && grant_q) ? rsp_data : '0;
        m1_pslverr = done && grant_q && rsp_err;
    end

endmodule

// File: tb/tb_apb_arbiter_2m.sv
// Directed bench for apb_arbiter_2m with a response scoreboard.
// A small slave model and per-master request counters drive the DUT.
module tb_apb_arbiter_2m;

    localparam int AW  = 34;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          m0_psel, m0_penable, m0_pwrite;
    logic [AW-1:0] m0_paddr;
    logic [DW-1:0] m0_pwdata;
    logic [SW-1:0] m0_pwstrb;
    logic          m0_pready, m0_pslverr;
    logic [DW-1:0] m0_prdata;
    logic          m1_psel, m1_penable, m1_pwrite;
    logic [AW-1:0] m1_paddr;
    logic [DW-1:0] m1_pwdata;
    logic [SW-1:0] m1_pwstrb;
    logic          m1_pready, m1_pslverr;
    logic [DW-1:0] m1_prdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pwstrb;
    logic          pready = 1'b0;
    logic [DW-1:0] prdata;
    logic          pslverr;

    apb_arbiter_2m #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_psel(m0_psel), .m0_penable(m0_penable),
        .m0_paddr(m0_paddr), .m0_pwrite(m0_pwrite),
        .m0_pwdata(m0_pwdata), .m0_pwstrb(m0_pwstrb),
        .m0_pready(m0_pready), .m0_prdata(m0_prdata),
        .m0_pslverr(m0_pslverr),
        .m1_psel(m1_psel), .m1_penable(m1_penable),
        .m1_paddr(m1_paddr), .m1_pwrite(m1_pwrite),
        .m1_pwdata(m1_pwdata), .m1_pwstrb(m1_pwstrb),
        .m1_pready(m1_pready), .m1_prdata(m1_prdata),
        .m1_pslverr(m1_pslverr),
        .psel(psel), .penable(penable), .paddr(paddr),
        .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    // Master models: psel held while transfers remain pending.
    int            pending [2];
    logic [AW-1:0] m_addr  [2];
    logic          m_wr    [2];
    logic [DW-1:0] m_wdata [2];
    logic [SW-1:0] m_strb  [2];

    assign m0_psel    = (pending[0] != 0);
    assign m0_penable = m0_psel;
    assign m0_paddr   = m_addr[0];
    assign m0_pwrite  = m_wr[0];
    assign m0_pwdata  = m_wdata[0];
    assign m0_pwstrb  = m_strb[0];
    assign m1_psel    = (pending[1] != 0);
    assign m1_penable = m1_psel;
    assign m1_paddr   = m_addr[1];
    assign m1_pwrite  = m_wr[1];
    assign m1_pwdata  = m_wdata[1];
    assign m1_pwstrb  = m_strb[1];

    // Slave model: pready after slv_wait ACCESS wait cycles.
    int            slv_wait = 0;
    int            wcnt = 0;
    bit            slv_hang = 1'b0;
    bit            slv_err = 1'b0;
    logic [DW-1:0] slv_data = '0;

    assign prdata  = slv_data;
    assign pslverr = pready & slv_err;

    always @(posedge clk) begin
        #1;
        if (psel && penable) begin
            pready = !slv_hang && (wcnt == slv_wait);
            wcnt++;
        end else begin
            pready = 1'b0;
            wcnt = 0;
        end
    end

    typedef struct {
        bit            m;
        logic [AW-1:0] addr;
        bit            wr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] strb;
        logic [DW-1:0] data;
        bit            err;
    } exp_t;

    exp_t sb[$];
    int   order[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int m, input logic [AW-1:0] a, input bit wr,
                       input logic [DW-1:0] wd, input logic [SW-1:0] st,
                       input int n);
        m_addr[m]  = a;
        m_wr[m]    = wr;
        m_wdata[m] = wd;
        m_strb[m]  = st;
        pending[m] = n;
    endtask

    task automatic expect_rsp(input bit m, input logic [AW-1:0] a,
                              input bit wr, input logic [DW-1:0] wd,
                              input logic [SW-1:0] st,
                              input logic [DW-1:0] d, input bit e);
        exp_t x;
        x.m = m; x.addr = a; x.wr = wr; x.wdata = wd;
        x.strb = st; x.data = d; x.err = e;
        sb.push_back(x);
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int c;
        c = 0;
        while ((pending[0] != 0 || pending[1] != 0) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        check(tag, 64'(pending[0] == 0 && pending[1] == 0), 64'd1);
    endtask

    // Response monitor: pops the scoreboard on every master pready.
    bit   mon_m;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst_n && (m0_pready || m1_pready)) begin
            mon_m = m1_pready;
            check("both_pready", 64'(m0_pready & m1_pready), 64'd0);
            order.push_back(int'(mon_m));
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("grant_master", 64'(mon_m), 64'(mon_e.m));
                check("paddr", 64'(paddr), 64'(mon_e.addr));
                check("pwrite", 64'(pwrite), 64'(mon_e.wr));
                check("pwdata", 64'(pwdata), 64'(mon_e.wdata));
                check("pwstrb", 64'(pwstrb), 64'(mon_e.strb));
                check("prdata", 64'(mon_m ? m1_prdata : m0_prdata),
                      64'(mon_e.data));
                check("pslverr", 64'(mon_m ? m1_pslverr : m0_pslverr),
                      64'(mon_e.err));
                check("other_quiet",
                      64'(mon_m ? {m0_prdata, m0_pslverr}
                                : {m1_prdata, m1_pslverr}), 64'd0);
            end
            if (pending[mon_m] > 0) pending[mon_m]--;
        end
    end

    initial begin
        int c;
        int n;
        rst_n = 1'b0;
        req(0, '0, 1'b0, '0, '0, 0);
        req(1, '0, 1'b0, '0, '0, 0);
        repeat (2) @(negedge clk);

        // Reset values.
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_m0_pready", 64'(m0_pready), 64'd0);
        check("rst_m1_pready", 64'(m1_pready), 64'd0);
        check("rst_m0_pslverr", 64'(m0_pslverr), 64'd0);
        check("rst_m1_pslverr", 64'(m1_pslverr), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single m0 read, two slave wait cycles.
        slv_wait = 2;
        slv_data = 32'hDEADBEEF;
        expect_rsp(0, 34'h010000000, 0, '0, '0, 32'hDEADBEEF, 0);
        req(0, 34'h010000000, 1'b0, '0, '0, 1);
        @(negedge clk);
        check("t1_psel_latency", 64'({psel, penable}), 64'b10);
        @(negedge clk);
        check("t1_access", 64'({psel, penable}), 64'b11);
        wait_idle("t1_done", 20);
        repeat (2) @(negedge clk);

        // Simultaneous requests straight after reset: m0 first.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        slv_wait = 1;
        slv_data = 32'h0BADF00D;
        expect_rsp(0, 34'h200, 1, 32'hA5A5A5A5, 4'hF, 32'h0BADF00D, 0);
        expect_rsp(1, 34'h300, 0, '0, '0, 32'h0BADF00D, 0);
        req(0, 34'h200, 1'b1, 32'hA5A5A5A5, 4'hF, 1);
        req(1, 34'h300, 1'b0, '0, '0, 1);
        c = 0;
        while (!m0_pready && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("t2_m0_done", 64'(m0_pready), 64'd1);
        @(negedge clk);
        check("t2_handoff_setup", 64'({psel, penable}), 64'b10);
        check("t2_handoff_addr", 64'(paddr), 64'h300);
        wait_idle("t2_done", 20);
        repeat (2) @(negedge clk);

        // Fairness: both request continuously.
        order.delete();
        slv_wait = 0;
        slv_data = 32'h11223344;
        for (int i = 0; i < 6; i++) begin
            expect_rsp(i[0], (i[0] ? 34'h500 : 34'h400), 0, '0, '0,
                       32'h11223344, 0);
        end
        req(0, 34'h400, 1'b0, '0, '0, 3);
        req(1, 34'h500, 1'b0, '0, '0, 3);
        wait_idle("t3_done", 100);
        check("t3_count", 64'(order.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < order.size())
                check("t3_order", 64'(order[i]), 64'(i % 2));
        end
        repeat (2) @(negedge clk);

        // Slave error on an m1 write.
        slv_wait = 1;
        slv_err = 1'b1;
        slv_data = 32'h55AA55AA;
        expect_rsp(1, 34'h600, 1, 32'h12345678, 4'h3, 32'h55AA55AA, 1);
        req(1, 34'h600, 1'b1, 32'h12345678, 4'h3, 1);
        c = 0;
        while (!m1_pready && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("t4_m1_pslverr", 64'({m1_pready, m1_pslverr}), 64'b11);
        @(negedge clk);
        check("t4_idle", 64'({psel, penable}), 64'b00);
        slv_err = 1'b0;
        wait_idle("t4_done", 20);
        repeat (2) @(negedge clk);

        // Timeout: slave never answers.
        slv_hang = 1'b1;
        slv_data = 32'hCAFEF00D;
        expect_rsp(0, 34'h700, 0, '0, '0, '0, 1);
        req(0, 34'h700, 1'b0, '0, '0, 1);
        c = 0;
        while (!penable && c < 10) begin
            @(negedge clk);
            c++;
        end
        n = 1;
        while (!m0_pready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_access_cycles", 64'(n), 64'd4);
        @(negedge clk);
        check("t5_psel_drop", 64'(psel), 64'd0);
        slv_hang = 1'b0;
        wait_idle("t5_done", 20);
        repeat (2) @(negedge clk);

        // Async reset during ACCESS, then a tie after release.
        slv_wait = 2;
        req(1, 34'h800, 1'b0, '0, '0, 1);
        c = 0;
        while (!penable && c < 10) begin
            @(negedge clk);
            c++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_psel", 64'({psel, penable}), 64'b00);
        check("t6_rst_no_rsp", 64'({m0_pready, m1_pready}), 64'b00);
        pending[1] = 0;
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        order.delete();
        slv_wait = 0;
        slv_data = 32'h77778888;
        expect_rsp(0, 34'h900, 0, '0, '0, 32'h77778888, 0);
        expect_rsp(1, 34'hA00, 0, '0, '0, 32'h77778888, 0);
        req(0, 34'h900, 1'b0, '0, '0, 1);
        req(1, 34'hA00, 1'b0, '0, '0, 1);
        wait_idle("t6_done", 40);
        check("t6_count", 64'(order.size()), 64'd2);
        if (order.size() > 0)
            check("t6_first", 64'(order[0]), 64'd0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
